// File: rtl/conv_filter_scheduler.sv
// Sequences one 3x3 convolution core over NUM_FILTERS filters: core reset, kernel/bias load,
// pixel streaming and result capture. Optional watchdog: define CONV_SCHED_TIMEOUT_EN.
module conv_filter_scheduler #(
  parameter int WIDTH          = 16,
  parameter int HEIGHT         = 16,
  parameter int CHANEL         = 4,
  parameter int NUM_FILTERS    = 8,
  parameter int OUT_PER_FILTER = (WIDTH - 2) * (HEIGHT - 2),
  parameter int AW             = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    filter_idx,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr,
  input  logic [31:0]   w_data,
  output logic          px_rd_en,
  output logic [AW-1:0] px_addr,
  output logic          core_resetn,
  output logic          load_kernel,
  output logic [31:0]   kernel,
  output logic          data_valid_in,
  input  logic          load_kernel_done,
  input  logic          valid_out,
  input  logic [31:0]   data_out_conv,
  output logic          out_wr_en,
  output logic [AW-1:0] out_addr,
  output logic [31:0]   out_data,
`ifdef CONV_SCHED_TIMEOUT_EN
  output logic          timeout,
`endif
  output logic [2:0]    state_dbg
);

  localparam int KWORDS = 9 * CHANEL + 1;
  localparam int KCW    = $clog2(KWORDS + 1);
  localparam int NW     = $clog2(OUT_PER_FILTER + 1);

  localparam logic [KCW-1:0] K_LAST  = KCW'(KWORDS - 1);
  localparam logic [AW-1:0]  PX_LAST = AW'(WIDTH * HEIGHT - 1);
  localparam logic [NW-1:0]  N_FULL  = NW'(OUT_PER_FILTER);
  localparam logic [AW-1:0]  W_STEP  = AW'(KWORDS);
  localparam logic [AW-1:0]  O_STEP  = AW'(OUT_PER_FILTER);
  localparam logic [7:0]     F_LAST  = 8'(NUM_FILTERS - 1);

  typedef enum logic [2:0] {
    IDLE, CORE_RST, LOAD_K, WAIT_K, STREAM, DRAIN, NEXT, DONE
  } state_t;

  state_t         state;
  logic           rst_cnt;
  logic [KCW-1:0] k;
  logic [NW-1:0]  n;
  logic [AW-1:0]  w_base;
  logic [AW-1:0]  out_base;
  logic           capture;
`ifdef CONV_SCHED_TIMEOUT_EN
  logic [15:0]    wd;
`endif

  // The weight memory's registered read data goes straight to the core, aligned with load_kernel.
  assign kernel    = w_data;
  assign state_dbg = state;

  // Core outputs count only while pixels are in flight, and never past a full filter.
  assign capture = ((state == STREAM) || (state == DRAIN)) && valid_out && (n != N_FULL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      filter_idx    <= 8'd0;
      w_rd_en       <= 1'b0;
      w_addr        <= '0;
      px_rd_en      <= 1'b0;
      px_addr       <= '0;
      core_resetn   <= 1'b0;
      load_kernel   <= 1'b0;
      data_valid_in <= 1'b0;
      out_wr_en     <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
      rst_cnt       <= 1'b0;
      k             <= '0;
      n             <= '0;
      w_base        <= '0;
      out_base      <= '0;
`ifdef CONV_SCHED_TIMEOUT_EN
      timeout       <= 1'b0;
      wd            <= 16'd0;
`endif
    end else begin
      load_kernel   <= w_rd_en;
      data_valid_in <= px_rd_en;
      done          <= 1'b0;
      out_wr_en     <= 1'b0;
      if (capture) begin
        out_wr_en <= 1'b1;
        out_data  <= data_out_conv;
        out_addr  <= out_base + AW'(n);
        n         <= n + NW'(1);
      end
      case (state)
        IDLE: begin
          core_resetn <= 1'b1;
          if (start) begin
            state       <= CORE_RST;
            busy        <= 1'b1;
            filter_idx  <= 8'd0;
            core_resetn <= 1'b0;
            rst_cnt     <= 1'b0;
            n           <= '0;
            w_base      <= '0;
            out_base    <= '0;
`ifdef CONV_SCHED_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
          end
        end
        CORE_RST: begin
          if (rst_cnt) begin
            state       <= LOAD_K;
            core_resetn <= 1'b1;
            w_rd_en     <= 1'b1;
            w_addr      <= w_base;
            k           <= '0;
          end else begin
            rst_cnt <= 1'b1;
          end
        end
        LOAD_K: begin
          if (k == K_LAST) begin
            w_rd_en <= 1'b0;
            state   <= WAIT_K;
`ifdef CONV_SCHED_TIMEOUT_EN
            wd      <= 16'd0;
`endif
          end else begin
            k      <= k + KCW'(1);
            w_addr <= w_addr + AW'(1);
          end
        end
        WAIT_K: begin
          if (load_kernel_done) begin
            state    <= STREAM;
            px_rd_en <= 1'b1;
            px_addr  <= '0;
          end
`ifdef CONV_SCHED_TIMEOUT_EN
          else if (wd == 16'd4095) begin
            timeout <= 1'b1;
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wd <= wd + 16'd1;
          end
`endif
        end
        STREAM: begin
          if (px_addr == PX_LAST) begin
            px_rd_en <= 1'b0;
            state    <= DRAIN;
`ifdef CONV_SCHED_TIMEOUT_EN
            wd       <= 16'd0;
`endif
          end else begin
            px_addr <= px_addr + AW'(1);
          end
        end
        DRAIN: begin
          // n == N_FULL means the last write is on the output registers this cycle.
          if (n == N_FULL) begin
            state <= NEXT;
          end
`ifdef CONV_SCHED_TIMEOUT_EN
          else if (valid_out) begin
            wd <= 16'd0;
          end else if (wd == 16'd4095) begin
            timeout <= 1'b1;
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wd <= wd + 16'd1;
          end
`endif
        end
        NEXT: begin
          if (filter_idx == F_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            filter_idx  <= filter_idx + 8'd1;
            n           <= '0;
            w_base      <= w_base + W_STEP;
            out_base    <= out_base + O_STEP;
            core_resetn <= 1'b0;
            rst_cnt     <= 1'b0;
            state       <= CORE_RST;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Bench for conv_filter_scheduler: weight-memory and ideal-core models, run table with
// randomized kernel/output data and output gaps, plus reset, idle and timeout sequences.
module tb_conv_filter_scheduler;
  localparam int W    = 16;
  localparam int H    = 16;
  localparam int CH   = 4;
  localparam int NF   = 3;
  localparam int AW   = 16;
  localparam int KW   = 9 * CH + 1;
  localparam int NPIX = W * H;
  localparam int OPF  = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, w_rd_en, px_rd_en, core_resetn, load_kernel, data_valid_in, out_wr_en;
  logic [7:0]    filter_idx;
  logic [AW-1:0] w_addr, px_addr, out_addr;
  logic [31:0]   w_data = 32'd0;
  logic [31:0]   kernel, out_data;
  logic          load_kernel_done = 1'b0;
  logic          core_valid = 1'b0;
  logic          inj_valid = 1'b0;
  logic          valid_out;
  logic [31:0]   data_out_conv = 32'd0;
  logic [2:0]    state_dbg;
`ifdef CONV_SCHED_TIMEOUT_EN
  logic          timeout;
`endif

  assign valid_out = core_valid | inj_valid;

  conv_filter_scheduler #(
    .WIDTH(W), .HEIGHT(H), .CHANEL(CH), .NUM_FILTERS(NF), .AW(AW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .filter_idx(filter_idx), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .px_rd_en(px_rd_en), .px_addr(px_addr), .core_resetn(core_resetn),
    .load_kernel(load_kernel), .kernel(kernel), .data_valid_in(data_valid_in),
    .load_kernel_done(load_kernel_done), .valid_out(valid_out), .data_out_conv(data_out_conv),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data),
`ifdef CONV_SCHED_TIMEOUT_EN
    .timeout(timeout),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- weight memory model ----------------
  logic [31:0] wmem [0:NF*KW-1];
  always @(posedge clk)
    if (w_rd_en && int'(w_addr) < NF * KW) w_data <= wmem[int'(w_addr)];

  // ---------------- ideal core model ----------------
  int  gap_mode = 0;
  bit  kd_block = 1'b0;
  int  core_k, core_px, gap_cnt;
  int  exp_idx = 0;
  logic [31:0]      core_q[$];
  logic [AW+31:0]   exp_q[$];

  function automatic bit emit_ok(input int mode, input int g);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (g % 3) == 0;
    return $urandom_range(0, 1) == 1;
  endfunction

  always @(posedge clk) begin
    if (!core_resetn) begin
      core_k = 0; core_px = 0; gap_cnt = 0;
      core_q.delete();
      load_kernel_done <= 1'b0;
      core_valid       <= 1'b0;
    end else begin
      if (load_kernel) begin
        core_k++;
        if (core_k == KW && !kd_block) load_kernel_done <= 1'b1;
      end
      // A 3x3 window completes once both row and column have reached index 2.
      if (data_valid_in) begin
        if ((core_px / W) >= 2 && (core_px % W) >= 2) core_q.push_back($urandom);
        core_px++;
      end
      gap_cnt++;
      core_valid <= 1'b0;
      if (core_q.size() > 0 && emit_ok(gap_mode, gap_cnt)) begin
        logic [31:0] d;
        d = core_q.pop_front();
        data_out_conv <= d;
        core_valid    <= 1'b1;
        exp_q.push_back({AW'(exp_idx), d});
        exp_idx++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int w_count, kw_count, px_count, wr_count, done_count, rst_runs, low_run;
  int first_w_cyc, last_w_cyc, done_cyc, f2_w0, f2_o0;
  int w_cyc_q[$];
  int px_cyc_q[$];
  logic timeout_at_done;

  task automatic clear_counts();
    w_count = 0; kw_count = 0; px_count = 0; wr_count = 0; done_count = 0;
    rst_runs = 0; low_run = 0; first_w_cyc = -1; last_w_cyc = -1; done_cyc = -1;
    f2_w0 = -1; f2_o0 = -1; exp_idx = 0; timeout_at_done = 1'b0;
    w_cyc_q.delete(); px_cyc_q.delete(); exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (w_rd_en) begin
        check("w_addr", w_addr, AW'(w_count));
        if (w_count == 0) first_w_cyc = cycle;
        if (filter_idx == 8'd2 && f2_w0 < 0) f2_w0 = int'(w_addr);
        last_w_cyc = cycle;
        w_cyc_q.push_back(cycle);
        w_count++;
      end
      if (load_kernel) begin
        if (w_cyc_q.size() == 0) check("load_kernel_orphan", 1, 0);
        else check("load_kernel_lag", cycle - w_cyc_q.pop_front(), 1);
        if (kw_count < NF * KW) check("kernel_word", kernel, wmem[kw_count]);
        kw_count++;
      end
      if (px_rd_en) begin
        check("px_addr", px_addr, AW'(px_count % NPIX));
        px_cyc_q.push_back(cycle);
        px_count++;
      end
      if (data_valid_in) begin
        if (px_cyc_q.size() == 0) check("data_valid_orphan", 1, 0);
        else check("data_valid_lag", cycle - px_cyc_q.pop_front(), 1);
      end
      if (out_wr_en) begin
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          logic [AW+31:0] e;
          e = exp_q.pop_front();
          check("out_addr", out_addr, e[AW+31:32]);
          check("out_data", out_data, e[31:0]);
        end
        if (filter_idx == 8'd2 && f2_o0 < 0) f2_o0 = int'(out_addr);
        wr_count++;
      end
      if (done) begin
        done_count++;
        done_cyc = cycle;
        check("busy_at_done", busy, 0);
`ifdef CONV_SCHED_TIMEOUT_EN
        timeout_at_done = timeout;
`endif
      end
      if (busy && !core_resetn) low_run++;
      else if (low_run > 0) begin
        check("core_reset_len", low_run, 2);
        rst_runs++;
        low_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    int gap;
    bit restart;
    bit inj;
    int exp_w;
    int exp_px;
    int exp_wr;
    int exp_rst;
  } vec_t;

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cycle;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    int t0;
    int t;
    clear_counts();
    gap_mode = v.gap;
    pulse_start(t0);
    check("busy_after_start", busy, 1);
    t = 0;
    while (w_count == 0 && t < 50) begin @(negedge clk); t++; end
    check("start_to_w_rd_en", first_w_cyc - t0, 3);
    if (v.inj) begin
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
    end
    if (v.restart) begin
      t = 0;
      while (px_count < 20 && t < 2000) begin @(negedge clk); t++; end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (done_count == 0 && t < 20000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    check("done_pulses", done_count, 1);
    check("w_reads", w_count, v.exp_w);
    check("kernel_loads", kw_count, v.exp_w);
    check("px_reads", px_count, v.exp_px);
    check("out_writes", wr_count, v.exp_wr);
    check("scoreboard_left", exp_q.size(), 0);
    check("core_reset_runs", rst_runs, v.exp_rst);
    check("filter2_w_addr0", f2_w0, 2 * KW);
    check("filter2_out_addr0", f2_o0, 2 * OPF);
    check("busy_after_done", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic any_strobe;
    vecs[0] = '{0, 1'b0, 1'b0, NF * KW, NF * NPIX, NF * OPF, NF};
    vecs[1] = '{1, 1'b0, 1'b1, NF * KW, NF * NPIX, NF * OPF, NF};
    vecs[2] = '{2, 1'b1, 1'b0, NF * KW, NF * NPIX, NF * OPF, NF};
    vecs[3] = '{2, 1'b1, 1'b1, NF * KW, NF * NPIX, NF * OPF, NF};
    for (int i = 0; i < NF * KW; i++) wmem[i] = $urandom;
    clear_counts();

    // Reset then idle
    #1;
    check("rst_core_resetn", core_resetn, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    any_strobe = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_strobe = any_strobe | busy | done | w_rd_en | px_rd_en | load_kernel |
                   data_valid_in | out_wr_en;
    end
    check("idle_strobes", any_strobe, 0);
    check("idle_core_resetn", core_resetn, 1);
    check("idle_filter_idx", filter_idx, 0);
    check("idle_w_addr", w_addr, 0);
    check("idle_out_addr", out_addr, 0);

    // Reset mid-LOAD_K, then a fresh run must restart at w_addr 0
    clear_counts();
    pulse_start(t0);
    begin
      int t;
      t = 0;
      while (w_count < 10 && t < 100) begin @(negedge clk); t++; end
    end
    check("midrun_reads_seen", w_count, 10);
    resetn = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_w_rd_en", w_rd_en, 0);
    check("midrst_w_addr", w_addr, 0);
    check("midrst_core_resetn", core_resetn, 0);
    check("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    check("midrst_no_done", done_count, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_case(vecs[i]);

`ifdef CONV_SCHED_TIMEOUT_EN
    // Core never reports kernel loaded: watchdog ends the run
    kd_block = 1'b1;
    clear_counts();
    gap_mode = 0;
    pulse_start(t0);
    begin
      int t;
      t = 0;
      while (done_count == 0 && t < 6000) begin @(negedge clk); t++; end
    end
    check("to_done", done_count, 1);
    check("to_flag_at_done", timeout_at_done, 1);
    check("to_wait_cycles", done_cyc - last_w_cyc, 4097);
    @(negedge clk);
    check("to_sticky", timeout, 1);
    pulse_start(t0);
    check("to_cleared_by_start", timeout, 0);
    resetn = 1'b0;
    kd_block = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
